// File: rtl/data_mem_ctrl.sv
// Data-memory sequencer: one load/store at a time onto a 1-cycle-latency word SRAM, RMW for SB/SH.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Store,
  input  logic [2:0]        Lw_Sw_OP,
  input  logic [31:0]       Req_Addr,
  input  logic [31:0]       Req_Wdata,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [31:0]       Rsp_Rdata,
  output logic              Rsp_Err,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  input  logic [31:0]       Mem_Rdata
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_e;

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          loc_q, loc_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         word_q, word_d;

  logic                req_legal;
  logic                req_mis;
  logic                req_err;
  logic [1:0]          req_loc;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_data;
  logic [31:0]         merged;
  logic                unused_addr_hi;

  always_comb begin
    unused_addr_hi = ^Req_Addr[31:ADDR_W+2];
  end

  // Request decode: legality, alignment and the effective byte location.
  always_comb begin
    if (Req_Store) begin
      req_legal = Lw_Sw_OP inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = Lw_Sw_OP inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    req_mis = ((Lw_Sw_OP[1:0] == 2'b01) && Req_Addr[0]) ||
              ((Lw_Sw_OP[1:0] == 2'b10) && (Req_Addr[1:0] != 2'b00));
    req_loc = Req_Addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    req_err = !req_legal || req_mis;
`else
    req_err = !req_legal;
    if (Lw_Sw_OP[1:0] == 2'b01) req_loc[0] = 1'b0;
    if (Lw_Sw_OP[1:0] == 2'b10) req_loc    = 2'b00;
`endif
  end

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    op_d    = op_q;
    addr_d  = addr_q;
    loc_d   = loc_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          store_d = Req_Store;
          op_d    = Lw_Sw_OP;
          addr_d  = Req_Addr[ADDR_W+1:2];
          loc_d   = req_loc;
          wdata_d = Req_Wdata;
          err_d   = req_err;
          if (req_err) begin
            state_d = RSP;
          end else if (Req_Store && (Lw_Sw_OP[1:0] == 2'b10)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:   state_d = WAIT;
      WAIT: begin
        word_d  = Mem_Rdata;
        state_d = store_q ? WR : RSP;
      end
      WR:   state_d = RSP;
      RSP: begin
        if (Rsp_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (loc_q)
      2'd0:    lane_b = word_q[7:0];
      2'd1:    lane_b = word_q[15:8];
      2'd2:    lane_b = word_q[23:16];
      default: lane_b = word_q[31:24];
    endcase
    lane_h = loc_q[1] ? word_q[31:16] : word_q[15:0];
    unique case (op_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_data = word_q;
      3'b100:  load_data = {24'd0, lane_b};
      3'b101:  load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase
  end

  // Store word: SW passes the request data; SB/SH splice it into the word read back.
  always_comb begin
    merged = word_q;
    unique case (op_q[1:0])
      2'b00: begin
        unique case (loc_q)
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (loc_q[1]) merged[31:16] = wdata_q[15:0];
        else          merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    Req_Ready = (state_q == IDLE);
    Rsp_Valid = (state_q == RSP);
    Rsp_Err   = (state_q == RSP) && err_q;
    Rsp_Rdata = ((state_q == RSP) && !err_q && !store_q) ? load_data : '0;
    Mem_En    = (state_q == RD) || (state_q == WR);
    Mem_We    = (state_q == WR);
    Mem_Addr  = Mem_En ? addr_q : '0;
    Mem_Wdata = (state_q == WR) ? merged : '0;
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      loc_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      loc_q   <= loc_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl: SRAM model, transaction-level reference and per-cycle compare.
module tb_data_mem_ctrl;
  localparam int unsigned AW = 10;

  logic          Clk = 1'b0;
  logic          Rst_N = 1'b0;
  logic          Req_Valid = 1'b0;
  logic          Req_Ready;
  logic          Req_Store = 1'b0;
  logic [2:0]    Lw_Sw_OP = '0;
  logic [31:0]   Req_Addr = '0;
  logic [31:0]   Req_Wdata = '0;
  logic          Rsp_Valid;
  logic          Rsp_Ready = 1'b0;
  logic [31:0]   Rsp_Rdata;
  logic          Rsp_Err;
  logic          Mem_En;
  logic          Mem_We;
  logic [AW-1:0] Mem_Addr;
  logic [31:0]   Mem_Wdata;
  logic [31:0]   Mem_Rdata = '0;

  data_mem_ctrl #(.ADDR_W(AW)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Store(Req_Store), .Lw_Sw_OP(Lw_Sw_OP), .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Rdata(Rsp_Rdata), .Rsp_Err(Rsp_Err),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // SRAM model with a backdoor write port driven by the stimulus.
  logic [31:0]   mem     [0:1023];
  logic [31:0]   ref_mem [0:1023];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_idx = '0;
  logic [31:0]   bd_val = '0;

  always @(posedge Clk) begin
    if (bd_en) mem[bd_idx] <= bd_val;
    if (Mem_En) begin
      if (Mem_We) mem[Mem_Addr] <= Mem_Wdata;
      else        Mem_Rdata <= mem[Mem_Addr];
    end
  end

  // Reference expectations: p_* for the pending request, e_* for the one in flight.
  int unsigned p_idx, e_idx;
  int          p_lat, p_rd, p_wr, e_lat, e_rd, e_wr;
  logic [31:0] p_rdata, p_wword, e_rdata, e_wword;
  logic        p_err, e_err;

  task automatic model(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    int unsigned sz, lo;
    logic [31:0] w, mask, v;
    bit legal, mis;
    p_idx = 32'(a[11:2]);
    lo    = 32'(a[1:0]);
    sz    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (op <= 3'd2) : (op <= 3'd2 || op == 3'd4 || op == 3'd5);
    mis   = (sz == 2 && lo % 2 != 0) || (sz == 4 && lo != 0);
    p_err = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
    p_err = p_err || mis;
`else
    lo = lo - lo % sz;
`endif
    p_rdata = '0; p_wword = '0; p_rd = 0; p_wr = 0; p_lat = 1;
    if (!p_err) begin
      w    = ref_mem[p_idx];
      mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
      if (!st) begin
        p_rd = 1; p_lat = 3;
        v = (w >> (8 * lo)) & mask;
        if (op[2] == 1'b0 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        p_rdata = v;
      end else if (sz == 4) begin
        p_wr = 1; p_lat = 2; p_wword = wd;
      end else begin
        p_rd = 1; p_wr = 3; p_lat = 4;
        p_wword = (w & ~(mask << (8 * lo))) | ((wd & mask) << (8 * lo));
      end
    end
  endtask

  bit          active = 0;
  int          k = 0;
  int          first_k = 0;
  int          last_k = 0;
  int          n_acc = 0;
  bit          acc_now = 0, hs_now = 0;
  logic [31:0] s_rdata = '0, last_rdata = '0;
  logic        s_err = 1'b0, last_err = 1'b0;

  always @(posedge Clk) begin
    if (!Rst_N) begin
      active = 0;
    end else if (hs_now) begin
      active = 0;
      if (e_wr != 0) ref_mem[e_idx] = e_wword;
      last_rdata = s_rdata; last_err = s_err; last_k = first_k;
    end else if (acc_now) begin
      active = 1; k = 1; first_k = 0; n_acc = 0;
      e_idx = p_idx; e_lat = p_lat; e_rd = p_rd; e_wr = p_wr;
      e_rdata = p_rdata; e_wword = p_wword; e_err = p_err;
    end else if (active) begin
      k++;
    end
  end

  always @(negedge Clk) begin
    bit exp_en;
    if (!Rst_N) begin
      chk("rst_req_ready", 32'(Req_Ready), 32'd1);
      chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
      chk("rst_rsp_err",   32'(Rsp_Err),   32'd0);
      chk("rst_rsp_rdata", Rsp_Rdata,      32'd0);
      chk("rst_mem_en",    32'(Mem_En),    32'd0);
      chk("rst_mem_we",    32'(Mem_We),    32'd0);
      chk("rst_mem_addr",  32'(Mem_Addr),  32'd0);
      chk("rst_mem_wdata", Mem_Wdata,      32'd0);
    end else if (!active) begin
      chk("idle_req_ready", 32'(Req_Ready), 32'd1);
      chk("idle_rsp_valid", 32'(Rsp_Valid), 32'd0);
      chk("idle_mem_en",    32'(Mem_En),    32'd0);
    end else begin
      exp_en = (k == e_rd) || (k == e_wr);
      chk("busy_req_ready", 32'(Req_Ready), 32'd0);
      chk("rsp_valid",      32'(Rsp_Valid), 32'(k >= e_lat));
      chk("mem_en",         32'(Mem_En),    32'(exp_en));
      if (exp_en) begin
        chk("mem_we",   32'(Mem_We),   32'(k == e_wr));
        chk("mem_addr", 32'(Mem_Addr), e_idx);
        if (k == e_wr) chk("mem_wdata", Mem_Wdata, e_wword);
      end
      if (Rsp_Valid) begin
        chk("rsp_rdata", Rsp_Rdata,    e_rdata);
        chk("rsp_err",   32'(Rsp_Err), 32'(e_err));
        if (first_k == 0) first_k = k;
      end
      if (Mem_En) n_acc++;
    end
    acc_now = Rst_N && Req_Valid && Req_Ready;
    hs_now  = Rst_N && active && Rsp_Valid && Rsp_Ready;
    s_rdata = Rsp_Rdata;
    s_err   = Rsp_Err;
  end

  task automatic pulse_reset();
    Rst_N = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_N = 1'b1;
  endtask

  task automatic bd(input int unsigned idx, input logic [31:0] val);
    bd_idx = AW'(idx); bd_val = val; bd_en = 1'b1;
    @(posedge Clk); #1;
    bd_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output bit ok);
    model(st, op, a, wd);
    Req_Store = st; Lw_Sw_OP = op; Req_Addr = a; Req_Wdata = wd;
    Req_Valid = 1'b1; Rsp_Ready = 1'b0;
    ok = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk); #1;
      if (active) begin ok = 1; break; end
    end
    Req_Valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 8 cycles");
    end
  endtask

  task automatic run_txn(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input int d, input bit garbage);
    int held;
    bit ok;
    issue(st, op, a, wd, ok);
    if (!ok) return;
    held = 0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      if (Rsp_Valid) begin held++; Rsp_Ready = (held > d); end
      if (garbage) begin
        Req_Valid = 1'($urandom_range(0, 1)); Req_Store = 1'($urandom_range(0, 1));
        Lw_Sw_OP = 3'($urandom_range(0, 7)); Req_Addr = $urandom;
      end
      @(posedge Clk); #1;
      if (!active) begin ok = 1; break; end
    end
    Req_Valid = 1'b0; Rsp_Ready = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout: got no handshake expected one within 60 cycles");
      pulse_reset();
    end
    chk("mem_word", mem[p_idx], ref_mem[p_idx]);
  endtask

  initial begin
    bit ok;
    logic [31:0] a;
    repeat (3) @(posedge Clk);
    #1 Rst_N = 1'b1;
    for (int unsigned i = 0; i < 32; i++) bd(i, $urandom);

    // Directed loads on 0x80FF7F01 at word 0x10.
    bd(16, 32'h80FF_7F01);
    run_txn(0, 3'b000, 32'h41, 0, 0, 0);
    chk("lb_41", last_rdata, 32'h0000_007F);
    chk("lb_41_lat", 32'(last_k), 32'd3);
    chk("lb_41_err", 32'(last_err), 32'd0);
    run_txn(0, 3'b000, 32'h43, 0, 0, 0);
    chk("lb_43", last_rdata, 32'hFFFF_FF80);
    run_txn(0, 3'b100, 32'h43, 0, 0, 0);
    chk("lbu_43", last_rdata, 32'h0000_0080);
    run_txn(0, 3'b001, 32'h42, 0, 0, 0);
    chk("lh_42", last_rdata, 32'hFFFF_80FF);
    run_txn(0, 3'b101, 32'h42, 0, 0, 0);
    chk("lhu_42", last_rdata, 32'h0000_80FF);
    run_txn(0, 3'b010, 32'h40, 0, 0, 0);
    chk("lw_40", last_rdata, 32'h80FF_7F01);

    // Read-modify-write stores.
    bd(16, 32'h1122_3344);
    run_txn(1, 3'b000, 32'h41, 32'h0000_00AB, 0, 0);
    chk("sb_41_mem", mem[16], 32'h1122_AB44);
    chk("sb_41_lat", 32'(last_k), 32'd4);
    chk("sb_41_acc", 32'(n_acc), 32'd2);
    chk("sb_41_err", 32'(last_err), 32'd0);
    bd(16, 32'h1122_3344);
    run_txn(1, 3'b001, 32'h42, 32'h0000_BEEF, 0, 0);
    chk("sh_42_mem", mem[16], 32'hBEEF_3344);
    run_txn(1, 3'b010, 32'h1000_0040, 32'hCAFE_F00D, 0, 0);
    chk("sw_wrap_mem", mem[16], 32'hCAFE_F00D);
    chk("sw_lat", 32'(last_k), 32'd2);

    // Backpressure: five stalled response cycles.
    run_txn(0, 3'b010, 32'h40, 0, 5, 1);
    chk("bp_rdata", last_rdata, 32'hCAFE_F00D);

    // Misaligned word load and illegal op.
    run_txn(0, 3'b010, 32'h42, 0, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_42_err", 32'(last_err), 32'd1);
    chk("lw_42_lat", 32'(last_k), 32'd1);
    chk("lw_42_acc", 32'(n_acc), 32'd0);
    chk("lw_42_rdata", last_rdata, 32'd0);
`else
    chk("lw_42_err", 32'(last_err), 32'd0);
    chk("lw_42_rdata", last_rdata, 32'hCAFE_F00D);
    chk("lw_42_lat", 32'(last_k), 32'd3);
`endif
    run_txn(0, 3'b011, 32'h40, 0, 0, 0);
    chk("op011_err", 32'(last_err), 32'd1);
    chk("op011_lat", 32'(last_k), 32'd1);
    chk("op011_acc", 32'(n_acc), 32'd0);

    // Reset during the SB read-wait cycle must abort without writing.
    bd(16, 32'h1122_3344);
    issue(1, 3'b000, 32'h41, 32'h0000_00AB, ok);
    for (int c = 0; c < 8 && ok; c++) begin
      if (active && k == 2) break;
      @(posedge Clk); #1;
    end
    Rst_N = 1'b0;
    #1;
    chk("abort_mem_en", 32'(Mem_En), 32'd0);
    chk("abort_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("abort_req_ready", 32'(Req_Ready), 32'd1);
    repeat (3) @(posedge Clk);
    #1 Rst_N = 1'b1;
    @(posedge Clk); #1;
    chk("abort_mem_word", mem[16], 32'h1122_3344);

    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      a[11:7] = '0;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2)), 1);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
